// File: rtl/redmule_tcdm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : redmule_tcdm_scheduler_if
// Description : Bundle between the TCDM scheduler, the streamer requesters
//               and the shared TCDM port.
//               master : the scheduler (drives grants, TCDM request, steering)
//               slave  : the surrounding streamer / memory side
//               Control : clear_i, enable_i
//               Loads   : ld_req_i, ld_gnt_o, ld_rvalid_o
//               Store   : st_req_i, st_urgent_i, st_gnt_o
//               TCDM    : tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i
//               Status  : owner_o, busy_o, err_o
// Revision    : 1.0 - initial release
// ============================================================================
interface redmule_tcdm_scheduler_if #(
    parameter int N_LD  = 3,
    parameter int OWN_W = 2
);
    logic              clear_i;
    logic              enable_i;
    logic [N_LD-1:0]   ld_req_i;
    logic [N_LD-1:0]   ld_gnt_o;
    logic              st_req_i;
    logic              st_urgent_i;
    logic              st_gnt_o;
    logic              tcdm_req_o;
    logic              tcdm_wen_o;
    logic              tcdm_gnt_i;
    logic              tcdm_r_valid_i;
    logic [OWN_W-1:0]  owner_o;
    logic [N_LD-1:0]   ld_rvalid_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        input  clear_i, enable_i, ld_req_i, st_req_i, st_urgent_i,
               tcdm_gnt_i, tcdm_r_valid_i,
        output ld_gnt_o, st_gnt_o, tcdm_req_o, tcdm_wen_o, owner_o,
               ld_rvalid_o, busy_o, err_o
    );

    modport slave (
        output clear_i, enable_i, ld_req_i, st_req_i, st_urgent_i,
               tcdm_gnt_i, tcdm_r_valid_i,
        input  ld_gnt_o, st_gnt_o, tcdm_req_o, tcdm_wen_o, owner_o,
               ld_rvalid_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/redmule_tcdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : redmule_tcdm_scheduler
// Description : Shares one TCDM port between N_LD load requesters (X, W, Y)
//               and one store requester (Z). Round-robin ownership with burst
//               locking, urgent-store preemption, and an in-order owner FIFO
//               that steers read responses back to the issuing load channel.
// Ports       : clk_i, rst_i (sync, active-high)
//               bus : redmule_tcdm_scheduler_if.master (requests, grants,
//                     TCDM handshake, response steering, status)
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_tcdm_scheduler #(
    parameter int N_LD      = 3,
    parameter int BURST_LEN = 4,
    parameter int MAX_OUTST = 2,
    parameter int OWN_W     = 2
) (
    input  wire logic                        clk_i,
    input  wire logic                        rst_i,
    redmule_tcdm_scheduler_if.master         bus
);

    localparam int               c_burst_w = $clog2(BURST_LEN + 1);
    localparam int               c_cnt_w   = $clog2(MAX_OUTST + 1);
    localparam int               c_ptr_w   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [OWN_W-1:0] c_st_own  = OWN_W'(N_LD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [OWN_W-1:0]       r_owner;
    logic [OWN_W-1:0]       r_rr;
    logic [c_burst_w-1:0]   r_burst;
    logic [OWN_W-1:0]       r_fifo [MAX_OUTST];
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_cnt_w-1:0]     r_fcnt;
    logic                   r_err;

    // First requester found scanning start, start+1, ... over {loads, store}.
    // Result is {found, index}.
    function automatic logic [OWN_W:0] f_pick(input logic [OWN_W-1:0] start,
                                              input logic [N_LD:0]    reqs);
        logic             found;
        logic [OWN_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i <= N_LD; i++) begin
            k = int'(start) + i;
            if (k > N_LD) k = k - (N_LD + 1);
            if (!found && reqs[k[OWN_W-1:0]]) begin
                found = 1'b1;
                idx   = k[OWN_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    logic [N_LD:0]      w_reqs;
    logic               w_active;
    logic               w_own_req;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_req;
    logic               w_hs;
    logic               w_urgent;
    logic               w_release;
    logic               w_push;
    logic               w_pop;
    logic [OWN_W-1:0]   w_rr_next;
    logic [OWN_W:0]     w_pick;
    logic               w_go;
    logic [OWN_W-1:0]   w_new_owner;
    logic [N_LD:0]      w_gnt_vec;
    logic [N_LD-1:0]    w_ld_rvalid;

    assign w_reqs       = {bus.st_req_i, bus.ld_req_i};
    assign w_active     = (r_state != S_IDLE);
    assign w_own_req    = w_reqs[r_owner];
    assign w_fifo_full  = (r_fcnt == c_cnt_w'(MAX_OUTST));
    assign w_fifo_empty = (r_fcnt == '0);
    assign w_urgent     = bus.st_urgent_i & bus.st_req_i;

    // Stores bypass the FIFO, so only loads are throttled by it.
    assign w_req  = w_active & w_own_req & bus.enable_i &
                    ((r_state == S_STORE) | ~w_fifo_full);
    assign w_hs   = w_req & bus.tcdm_gnt_i;
    assign w_push = w_hs & (r_state == S_LOAD);
    assign w_pop  = bus.tcdm_r_valid_i & ~w_fifo_empty;

    // Raw request low releases; a request masked by a full FIFO does not.
    assign w_release = w_active &
                       (~w_own_req |
                        (w_hs & (r_burst == c_burst_w'(BURST_LEN - 1))) |
                        ((r_state == S_LOAD) & w_urgent & w_hs));

    assign w_rr_next   = (r_owner == c_st_own) ? '0 : r_owner + 1'b1;
    // Arbitration scans from the pointer that will be in effect after release.
    assign w_pick      = f_pick(w_active ? w_rr_next : r_rr, w_reqs);
    assign w_go        = w_urgent | w_pick[OWN_W];
    assign w_new_owner = w_urgent ? c_st_own : w_pick[OWN_W-1:0];

    always_comb begin
        w_gnt_vec = '0;
        if (w_active) w_gnt_vec[r_owner] = w_hs;
    end

    always_comb begin
        w_ld_rvalid = '0;
        if (w_pop) w_ld_rvalid[r_fifo[r_rptr]] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_burst <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_fcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            // Responses drain even while disabled.
            if (w_push) begin
                r_fifo[r_wptr] <= r_owner;
                r_wptr <= (r_wptr == c_ptr_w'(MAX_OUTST - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_w'(MAX_OUTST - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (bus.tcdm_r_valid_i && w_fifo_empty) r_err <= 1'b1;

            if (bus.enable_i) begin
                if (!w_active || w_release) begin
                    if (w_active) begin
                        r_rr    <= w_rr_next;
                        r_burst <= '0;
                    end
                    if (w_go) begin
                        r_state <= (w_new_owner == c_st_own) ? S_STORE : S_LOAD;
                        r_owner <= w_new_owner;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end else if (w_hs) begin
                    r_burst <= r_burst + 1'b1;
                end
            end
        end
    end

    assign bus.ld_gnt_o    = w_gnt_vec[N_LD-1:0];
    assign bus.st_gnt_o    = w_gnt_vec[N_LD];
    assign bus.tcdm_req_o  = w_req;
    assign bus.tcdm_wen_o  = (r_state != S_STORE);
    assign bus.owner_o     = r_owner;
    assign bus.ld_rvalid_o = w_ld_rvalid;
    assign bus.busy_o      = w_active | ~w_fifo_empty;
    assign bus.err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_redmule_tcdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_redmule_tcdm_scheduler
// Description : Directed self-checking bench for redmule_tcdm_scheduler.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled 1 unit after that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_tcdm_scheduler;

    logic clk;
    logic rst;
    logic auto_rv;
    int   n_total;
    int   n_pass;
    int   n_fail;

    redmule_tcdm_scheduler_if #(.N_LD(3), .OWN_W(2)) bus ();

    redmule_tcdm_scheduler #(
        .N_LD      (3),
        .BURST_LEN (4),
        .MAX_OUTST (2),
        .OWN_W     (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; in auto mode return a read response one cycle
    // after every load grant.
    task automatic next_cycle();
        logic g;
        g = |bus.ld_gnt_o;
        @(posedge clk);
        #1;
        if (auto_rv) bus.tcdm_r_valid_i = g;
    endtask

    initial begin
        int          o;
        int          po;
        logic [1:0]  eo;
        logic [2:0]  eg;
        logic [2:0]  erv;

        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        auto_rv = 1'b0;
        rst     = 1'b1;
        bus.clear_i        = 1'b0;
        bus.enable_i       = 1'b1;
        bus.ld_req_i       = 3'b000;
        bus.st_req_i       = 1'b0;
        bus.st_urgent_i    = 1'b0;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        chk("rst_owner", bus.owner_o, 2'd0);
        chk("rst_req", bus.tcdm_req_o, 1'b0);
        chk("rst_wen", bus.tcdm_wen_o, 1'b1);
        chk("rst_ldgnt", bus.ld_gnt_o, 3'b000);
        chk("rst_stgnt", bus.st_gnt_o, 1'b0);
        chk("rst_rv", bus.ld_rvalid_o, 3'b000);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        rst = 1'b0;

        // ---------------- single X burst ----------------
        next_cycle();
        bus.ld_req_i   = 3'b001;
        bus.tcdm_gnt_i = 1'b1;
        auto_rv        = 1'b1;
        #1;
        chk("t1_latency", bus.tcdm_req_o, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            #1;
            n_total++;
            if (bus.ld_gnt_o === 3'b001) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL t1_gnt: observed %0h expected %0h", bus.ld_gnt_o, 3'b001);
            end
            erv = (c == 1) ? 3'b000 : 3'b001;
            n_total++;
            if (bus.ld_rvalid_o === erv) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL t1_rv: observed %0h expected %0h", bus.ld_rvalid_o, erv);
            end
        end
        chk("t1_owner", bus.owner_o, 2'd0);
        next_cycle();
        bus.ld_req_i = 3'b000;
        #1;
        chk("t1_nogrant", bus.ld_gnt_o, 3'b000);
        chk("t1_rv_last", bus.ld_rvalid_o, 3'b001);
        chk("t1_busy_drain", bus.busy_o, 1'b1);
        next_cycle();
        #1;
        chk("t1_idle", bus.busy_o, 1'b0);
        chk("t1_rv_done", bus.ld_rvalid_o, 3'b000);

        // ---------------- round robin over X, W, Y, Z ----------------
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.ld_req_i = 3'b111;
        bus.st_req_i = 1'b1;
        #1;
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            #1;
            o   = ((c - 1) / 4) % 4;
            po  = (c >= 2) ? ((c - 2) / 4) % 4 : 3;
            eo  = 2'(o);
            eg  = (o < 3) ? 3'(1 << o) : 3'b000;
            erv = (po < 3) ? 3'(1 << po) : 3'b000;
            chk("t2_owner", bus.owner_o, eo);
            chk("t2_wen", bus.tcdm_wen_o, (o != 3));
            chk("t2_ldgnt", bus.ld_gnt_o, eg);
            chk("t2_stgnt", bus.st_gnt_o, (o == 3));
            chk("t2_rv", bus.ld_rvalid_o, erv);
        end
        next_cycle();
        bus.ld_req_i = 3'b000;
        bus.st_req_i = 1'b0;
        #1;
        chk("t2_rv_tail", bus.ld_rvalid_o, 3'b001);
        next_cycle();
        #1;
        chk("t2_idle", bus.busy_o, 1'b0);

        // ---------------- W owner, FIFO full throttling ----------------
        rst     = 1'b1;
        auto_rv = 1'b0;
        next_cycle();
        bus.tcdm_r_valid_i = 1'b0;
        rst          = 1'b0;
        bus.ld_req_i = 3'b010;
        #1;
        next_cycle(); #1;
        chk("t3_owner", bus.owner_o, 2'd1);
        chk("t3_gnt1", bus.ld_gnt_o, 3'b010);
        next_cycle(); #1;
        chk("t3_gnt2", bus.ld_gnt_o, 3'b010);
        next_cycle(); #1;
        chk("t3_full_req", bus.tcdm_req_o, 1'b0);
        chk("t3_full_gnt", bus.ld_gnt_o, 3'b000);
        next_cycle(); #1;
        chk("t3_hold_owner", bus.owner_o, 2'd1);
        chk("t3_hold_req", bus.tcdm_req_o, 1'b0);
        next_cycle();
        bus.tcdm_r_valid_i = 1'b1;
        #1;
        chk("t3_rv", bus.ld_rvalid_o, 3'b010);
        chk("t3_req_on_pop", bus.tcdm_req_o, 1'b0);
        next_cycle();
        bus.tcdm_r_valid_i = 1'b0;
        #1;
        chk("t3_gnt3", bus.ld_gnt_o, 3'b010);

        // ---------------- reset with two reads outstanding ----------------
        next_cycle();
        rst            = 1'b1;
        bus.ld_req_i   = 3'b000;
        bus.tcdm_gnt_i = 1'b0;
        #1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("t6_owner", bus.owner_o, 2'd0);
        chk("t6_busy", bus.busy_o, 1'b0);
        chk("t6_req", bus.tcdm_req_o, 1'b0);
        chk("t6_wen", bus.tcdm_wen_o, 1'b1);
        chk("t6_err", bus.err_o, 1'b0);
        next_cycle();
        bus.tcdm_r_valid_i = 1'b1;
        #1;
        chk("t5_stray_rv", bus.ld_rvalid_o, 3'b000);
        next_cycle();
        bus.tcdm_r_valid_i = 1'b0;
        #1;
        chk("t5_err_set", bus.err_o, 1'b1);
        next_cycle(); #1;
        chk("t5_err_sticky", bus.err_o, 1'b1);
        bus.clear_i = 1'b1;
        next_cycle();
        bus.clear_i = 1'b0;
        #1;
        chk("t5_err_clear", bus.err_o, 1'b0);

        // ---------------- urgent store preemption ----------------
        next_cycle();
        bus.ld_req_i = 3'b001;
        #1;
        next_cycle(); #1;
        chk("t4_owner_x", bus.owner_o, 2'd0);
        chk("t4_req_x", bus.tcdm_req_o, 1'b1);
        bus.st_req_i    = 1'b1;
        bus.st_urgent_i = 1'b1;
        #1;
        chk("t4_wait_owner", bus.owner_o, 2'd0);
        chk("t4_wait_gnt", bus.ld_gnt_o, 3'b000);
        for (int c = 0; c < 2; c++) begin
            next_cycle(); #1;
            n_total++;
            if (bus.owner_o === 2'd0) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL t4_hold_owner: observed %0h expected %0h", bus.owner_o, 2'd0);
            end
            n_total++;
            if (bus.tcdm_req_o === 1'b1) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL t4_hold_req: observed %0h expected %0h", bus.tcdm_req_o, 1'b1);
            end
        end
        next_cycle();
        bus.tcdm_gnt_i = 1'b1;
        #1;
        chk("t4_hs_ldgnt", bus.ld_gnt_o, 3'b001);
        chk("t4_hs_stgnt", bus.st_gnt_o, 1'b0);
        next_cycle(); #1;
        chk("t4_store_owner", bus.owner_o, 2'd3);
        chk("t4_store_wen", bus.tcdm_wen_o, 1'b0);
        chk("t4_store_gnt", bus.st_gnt_o, 1'b1);
        chk("t4_store_ldgnt", bus.ld_gnt_o, 3'b000);
        next_cycle();
        bus.enable_i = 1'b0;
        #1;
        chk("t7_dis_req", bus.tcdm_req_o, 1'b0);
        chk("t7_dis_gnt", bus.st_gnt_o, 1'b0);
        next_cycle(); #1;
        chk("t7_dis_owner", bus.owner_o, 2'd3);
        bus.enable_i = 1'b1;
        #1;
        chk("t7_en_req", bus.tcdm_req_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/redmule_tcdm_scheduler.md
Name: redmule_tcdm_scheduler

Overview:
- Sequences the single shared TCDM port of the RedMulE streamer between three load requesters (X, W, Y sources) and one store requester (Z sink).
- Grants one owner at a time, in round-robin order with burst locking and an urgent-store preemption path.
- Steers read responses back to the issuing load channel through an in-order owner FIFO.
- Drives the select and handshake signals that replace the streamer's dynamic muxes.

Parameters:
- N_LD, 3, number of load requesters (index 0=X, 1=W, 2=Y).
- BURST_LEN, 4, maximum handshakes an owner keeps the port before rotation is forced.
- MAX_OUTST, 2, depth of the outstanding-read owner FIFO.
- OWN_W, 2, width of owner encoding; values 0..N_LD-1 are loads and N_LD is the store.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- enable_i  in  1  when low: tcdm_req_o forced 0, all state held
- ld_req_i  in  N_LD  load requests; each held stable until granted
- ld_gnt_o  out  N_LD  load grants (one-hot or zero)
- st_req_i  in  1  store request
- st_urgent_i  in  1  Z path nearly full; requests preemption
- st_gnt_o  out  1  store grant
- tcdm_req_o  out  1  request to TCDM
- tcdm_wen_o  out  1  1=read, 0=write
- tcdm_gnt_i  in  1  TCDM grant
- tcdm_r_valid_i  in  1  read response valid
- owner_o  out  OWN_W  current owner; drives the request-side mux select
- ld_rvalid_o  out  N_LD  response valid, steered one-hot to the channel at the FIFO head
- busy_o  out  1  owner active or FIFO non-empty
- err_o  out  1  sticky; set when a response arrives while the FIFO is empty

Behaviour:
- Reset/clear: state IDLE, owner_o=0, rr pointer=0, burst count=0, FIFO empty, err_o=0.
  - All request/grant/valid outputs are 0 at reset; tcdm_wen_o=1.
- States:
  - IDLE: no owner.
  - LOAD: owner is X, W or Y.
  - STORE: owner is Z.
- IDLE transitions:
  - If st_urgent_i&st_req_i, go to STORE.
  - Otherwise pick the first requester in the order rr, rr+1, ... over {X, W, Y, Z} (wraps from Z to X).
  - The new owner is registered; its first request is forwarded the next cycle (1-cycle arbitration latency).
- In LOAD/STORE:
  - tcdm_req_o = owner's req & enable_i & (STORE or FIFO not full).
  - tcdm_wen_o = (state==LOAD).
  - Owner's gnt = tcdm_gnt_i & tcdm_req_o; grant is combinational from tcdm_gnt_i.
- Handshake = tcdm_req_o & tcdm_gnt_i.
  - Increments the burst count.
  - In LOAD, also pushes the owner index into the FIFO.
- Release happens in a cycle where the owner's req is low, or on the handshake that makes burst count reach BURST_LEN. On release:
  - rr = owner+1 (wrapping) and count=0.
  - Next state is chosen by the same pick as IDLE, evaluated that cycle; if nothing is requesting, go to IDLE.
- Preemption: in LOAD with st_urgent_i&st_req_i, release at the next handshake or at the next cycle where the owner's req is low. Go to STORE; rr is set to owner+1.
- Never switch owner while the owner's request is asserted and not yet granted.
- A masked request (enable_i low or FIFO full) does not count as req-low for release.
- FIFO:
  - Push on load handshake; pop on tcdm_r_valid_i.
  - Full is evaluated at the start of the cycle: no push-through-pop when full.
  - Simultaneous push and pop while not full is allowed.
  - ld_rvalid_o[head] = tcdm_r_valid_i when the FIFO is non-empty.
- r_valid with empty FIFO: sets err_o, no pop, ld_rvalid_o stays 0.
- Reset/clear mid-operation discards FIFO contents; later stray responses set err_o.
- enable_i low: holds state, counters and FIFO.
  - Responses are still popped and steered, so in-flight reads drain.

Test Plan:
- X req held, tcdm_gnt_i=1 every cycle, r_valid 1 cycle after each grant:
  - owner X at cycle 1; exactly 4 grants in cycles 1-4, then release.
  - Outputs ld_rvalid_o=3'b001 four times, busy_o falls after the last response.
- X, W, Y, Z all requesting continuously with gnt=1 and timely responses → ownership sequence X, W, Y, Z, X, each for 4 handshakes; wen=0 only during Z.
- W owner, no responses returned (MAX_OUTST=2):
  - after 2 grants, tcdm_req_o=0 and W holds ownership.
  - One r_valid → ld_rvalid_o=3'b010, then the third grant next cycle.
- X owner, tcdm_gnt_i=0 for 3 cycles, st_urgent_i&st_req_i raised at cycle 0:
  - owner stays X, tcdm_req_o stays 1.
  - When gnt arrives, the handshake completes and STORE is entered next cycle.
- Response with empty FIFO → err_o=1 and stays 1 until rst_i or clear_i; ld_rvalid_o=0.
- rst_i asserted with 2 reads outstanding → next cycle all outputs are at reset values and FIFO empty; a later r_valid sets err_o.
